// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Font entries are active-low a..g with a in bit 6.
package seg7_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Index n holds the glyph for hex digit n (entry 0 is the rightmost).
  localparam logic [15:0][6:0] FONT = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low a..g segment pattern.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  nibble_t    nib,
  output logic [6:0] seg
);

  assign seg = FONT[nib];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Round-robin scanner for a multiplexed common-anode display: per-frame input
// snapshot, dead-time blank at each slot start, registered active-low pins.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK          = 100,
  parameter int DIGIT        = 4,
  parameter int SLOT_CYCLES  = CLK * 1000,
  parameter int BLANK_CYCLES = CLK
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4*DIGIT-1:0] value,
  input  logic [DIGIT-1:0]   dp,
  input  logic [DIGIT-1:0]   en,
  input  logic               lz_blank,
  output logic [7:0]         abcdefgh,
  output logic [DIGIT-1:0]   digit,
  output logic               frame_start
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int IW = (DIGIT > 1) ? $clog2(DIGIT) : 1;

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [DIGIT-1:0][3:0]   sh_value;
  logic [DIGIT-1:0]        sh_dp;
  logic [DIGIT-1:0]        sh_en;
  logic                    sh_lz;
  logic                    slot_end;
  logic                    idx_last;
  logic                    frame_end;
  logic                    all_zero;
  logic [DIGIT-1:0]        lz_mask;
  nibble_t                 cur_nib;
  logic [6:0]              cur_seg;

  assign slot_end  = (cnt == CW'(SLOT_CYCLES - 1));
  assign idx_last  = (idx == IW'(DIGIT - 1));
  assign frame_end = slot_end && idx_last;
  assign cur_nib   = sh_value[idx];

  // Digit i blanks when it and every digit to its left hold zero; digit 0 never does.
  always_comb begin
    all_zero = 1'b1;
    lz_mask  = '0;
    for (int i = DIGIT - 1; i >= 0; i--) begin
      all_zero   = all_zero && (sh_value[i] == 4'h0);
      lz_mask[i] = sh_lz && all_zero && (i != 0);
    end
  end

  seg7_hex_decoder u_dec (
    .nib (cur_nib),
    .seg (cur_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      sh_value    <= '0;
      sh_dp       <= '0;
      sh_en       <= '0;
      sh_lz       <= 1'b0;
      abcdefgh    <= 8'hFF;
      digit       <= '1;
      frame_start <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end) idx <= idx_last ? '0 : idx + IW'(1);

      frame_start <= frame_end;
      if (frame_end) begin
        sh_value <= value;
        sh_dp    <= dp;
        sh_en    <= en;
        sh_lz    <= lz_blank;
      end

      // Disabled digits stay dark for the whole slot so the duty cycle is uniform.
      if ((cnt < CW'(BLANK_CYCLES)) || !sh_en[idx]) begin
        abcdefgh <= 8'hFF;
        digit    <= '1;
      end else begin
        abcdefgh <= {(lz_mask[idx] ? SEG_OFF : cur_seg), ~sh_dp[idx]};
        digit    <= ~(DIGIT'(1) << idx);
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl at DIGIT=4, SLOT_CYCLES=8, BLANK_CYCLES=2.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic [3:0]  en = 4'h0;
  logic        lz_blank = 1'b0;
  logic [7:0]  abcdefgh;
  logic [3:0]  digit;
  logic        frame_start;

  seg7_scan_ctrl #(
    .CLK          (1),
    .DIGIT        (4),
    .SLOT_CYCLES  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .dp          (dp),
    .en          (en),
    .lz_blank    (lz_blank),
    .abcdefgh    (abcdefgh),
    .digit       (digit),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        lz;
  } in_t;

  typedef struct {
    in_t        in;
    int         idx;
    logic [7:0] seg;
    logic [3:0] dig;
  } vec_t;

  localparam logic [6:0] TB_FONT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  in_t  hist [2048];
  int   k = 0;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got=%0h want=%0h", nm, k, act, exp);
    end
  endtask

  // Reference: cycle k shows the state of cycle k-1; frame f shows the inputs
  // present on the last cycle of frame f-1 (zeros for frame 0).
  function automatic void model(input int kk, output logic [7:0] a,
                                output logic [3:0] d, output logic fs);
    int s, cnt, i, f, nib;
    in_t sh;
    logic [6:0] seg;
    a  = 8'hFF;
    d  = 4'hF;
    fs = 1'b0;
    if (kk == 0) return;
    s   = kk - 1;
    cnt = s % 8;
    i   = (s / 8) % 4;
    f   = s / 32;
    if (f == 0) sh = '0;
    else        sh = hist[32 * f - 1];
    fs = (kk % 32 == 0);
    if (cnt >= 2 && sh.en[i]) begin
      nib = int'((sh.value >> (4 * i)) & 16'hF);
      seg = TB_FONT[nib];
      if (sh.lz && i > 0 && (sh.value >> (4 * i)) == 16'h0) seg = 7'h7F;
      a = {seg, ~sh.dp[i]};
      d = ~(4'b0001 << i);
    end
  endfunction

  task automatic check_model();
    logic [7:0] ea;
    logic [3:0] ed;
    logic       ef;
    model(k, ea, ed, ef);
    chk("seg", 32'(abcdefgh), 32'(ea));
    chk("digit", 32'(digit), 32'(ed));
    chk("frame_start", 32'(frame_start), 32'(ef));
  endtask

  task automatic step();
    if (k >= 2047) begin
      $display("FAIL cycle_budget k=%0d", k);
      $fatal(1, "cycle budget exceeded");
    end
    hist[k] = {value, dp, en, lz_blank};
    @(posedge clk);
    k++;
    @(negedge clk);
    check_model();
  endtask

  task automatic apply(input in_t v);
    value    = v.value;
    dp       = v.dp;
    en       = v.en;
    lz_blank = v.lz;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_seg", 32'(abcdefgh), 32'hFF);
      chk("rst_digit", 32'(digit), 32'hF);
      chk("rst_fs", 32'(frame_start), 32'h0);
    end
    rst = 1'b0;
    k   = 0;
  endtask

  initial begin
    int fs_cnt, fs_at, k0, f, target;

    vecs[0]  = '{'{16'h1234, 4'h0, 4'hF, 1'b0}, 0, 8'h99, 4'b1110};
    vecs[1]  = '{'{16'h1234, 4'h0, 4'hF, 1'b0}, 1, 8'h0D, 4'b1101};
    vecs[2]  = '{'{16'h1234, 4'h0, 4'hF, 1'b0}, 2, 8'h25, 4'b1011};
    vecs[3]  = '{'{16'h1234, 4'h0, 4'hF, 1'b0}, 3, 8'h9F, 4'b0111};
    vecs[4]  = '{'{16'h0005, 4'h0, 4'hF, 1'b1}, 3, 8'hFF, 4'b0111};
    vecs[5]  = '{'{16'h0005, 4'h0, 4'hF, 1'b1}, 1, 8'hFF, 4'b1101};
    vecs[6]  = '{'{16'h0005, 4'h0, 4'hF, 1'b1}, 0, 8'h49, 4'b1110};
    vecs[7]  = '{'{16'h0000, 4'h0, 4'hF, 1'b1}, 0, 8'h03, 4'b1110};
    vecs[8]  = '{'{16'h0000, 4'b0100, 4'hF, 1'b1}, 2, 8'hFE, 4'b1011};
    vecs[9]  = '{'{16'h8888, 4'h0, 4'hF, 1'b0}, 0, 8'h01, 4'b1110};
    vecs[10] = '{'{16'h1234, 4'h0, 4'b0101, 1'b0}, 1, 8'hFF, 4'b1111};
    vecs[11] = '{'{16'h1234, 4'h0, 4'b0101, 1'b0}, 2, 8'h25, 4'b1011};

    // Reset with live inputs present; first frame must stay dark.
    value = 16'hFFFF;
    en    = 4'hF;
    do_reset(3);
    check_model();
    fs_cnt = 0;
    fs_at  = -1;
    repeat (40) begin
      step();
      if (frame_start) begin
        fs_cnt++;
        fs_at = k;
      end
    end
    chk("fs_count", 32'(fs_cnt), 32'd1);
    chk("fs_at", 32'(fs_at), 32'd32);

    // Table: load inputs, wait for the frame that captures them, probe one slot.
    for (int n = 0; n < 12; n++) begin
      apply(vecs[n].in);
      k0     = k;
      f      = (k0 + 32) / 32;
      target = 32 * f + 8 * vecs[n].idx + 5;
      while (k < target) step();
      chk($sformatf("vec%0d_seg", n), 32'(abcdefgh), 32'(vecs[n].seg));
      chk($sformatf("vec%0d_digit", n), 32'(digit), 32'(vecs[n].dig));
    end

    // Snapshot: a mid-frame value change must wait for the next frame.
    apply('{16'h1234, 4'h0, 4'hF, 1'b0});
    k0 = k;
    f  = (k0 + 32) / 32;
    while (k < 32 * f + 9) step();
    value = 16'h8888;
    while (k < 32 * f + 13) step();
    chk("snap_s1", 32'(abcdefgh), 32'h0D);
    while (k < 32 * f + 21) step();
    chk("snap_s2", 32'(abcdefgh), 32'h25);
    while (k < 32 * f + 29) step();
    chk("snap_s3", 32'(abcdefgh), 32'h9F);
    while (k < 32 * (f + 1)) step();
    chk("snap_fs", 32'(frame_start), 32'h1);
    while (k < 32 * (f + 1) + 5) step();
    chk("snap_new_seg", 32'(abcdefgh), 32'h01);
    chk("snap_new_digit", 32'(digit), 32'(4'b1110));

    // Reset while cnt=5, idx=2; scan must restart from slot 0, cnt 0.
    while (k % 32 != 21) step();
    do_reset(1);
    check_model();
    while (k < 32) step();
    chk("rst_restart_fs", 32'(frame_start), 32'h1);

    // Random inputs with zero-heavy values, checked every cycle by the model.
    repeat (600) begin
      if ($urandom_range(9) == 0) begin
        case ($urandom_range(4))
          0:       value = 16'($urandom);
          1:       value = 16'($urandom) & 16'h0FFF;
          2:       value = 16'($urandom) & 16'h00FF;
          3:       value = 16'($urandom) & 16'h000F;
          default: value = 16'h0;
        endcase
        dp       = 4'($urandom);
        en       = 4'($urandom);
        lz_blank = 1'($urandom);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
